// File: rtl/ls_pkg.sv
// Shared types and defaults for the load/store unit.
// The timeout counter width is derived from the abort limit.
package ls_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } ls_state_e;

  localparam int LS_AW      = 8;
  localparam int LS_DW      = 8;
  localparam int LS_PW      = 2;
  localparam int LS_TIMEOUT = 15;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  localparam int LS_CW = cnt_width(LS_TIMEOUT);

endpackage

// File: rtl/ls_timer.sv
// Request-cycle counter: cleared on accept, counts un-acked REQ cycles.
// expired flags the counting cycle that brings the count up to LIMIT.
module ls_timer
  import ls_pkg::*;
#(
  parameter int LIMIT = LS_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Compare against LIMIT-1 so the abort decision is made in the same cycle
  // the count would reach LIMIT.
  assign expired = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: one memory op at a time over req/ack, with timeout abort.
// Loads complete through the register-file write port in the FIN cycle.
//
// state | meaning
// IDLE  | ready for a new op; op_valid latches the operation
// REQ   | mem_req held until mem_ack or timeout
// FIN   | one-cycle done pulse; rf write for successful loads
module ls_unit
  import ls_pkg::*;
#(
  parameter int AW      = LS_AW,
  parameter int DW      = LS_DW,
  parameter int PW      = LS_PW,
  parameter int TIMEOUT = LS_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic          op_store,
  input  logic [AW-1:0] op_addr,
  input  logic [DW-1:0] op_wdata,
  input  logic [PW-1:0] op_dst,
  output logic          done,
  output logic          err,
  input  logic          err_clr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_we,
  output logic [PW-1:0] rf_ptr_w,
  output logic [DW-1:0] rf_di
);

  ls_state_e     state, state_nxt;
  logic          store_q;
  logic          abort_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [PW-1:0] dst_q;
  logic          tmr_clear;
  logic          tmr_en;
  logic          tmr_expired;
  logic          accept;

  ls_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    accept    = 1'b0;
    op_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    rf_we     = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept    = 1'b1;
          tmr_clear = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        mem_we  = store_q;
        if (mem_ack) begin
          state_nxt = FIN;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        rf_we     = !store_q && !abort_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dst_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        store_q <= op_store;
        addr_q  <= op_addr;
        wdata_q <= op_wdata;
        dst_q   <= op_dst;
        abort_q <= 1'b0;
      end
      if (state == REQ && mem_ack && !store_q) rdata_q <= mem_rdata;
      if (tmr_expired) abort_q <= 1'b1;
    end
  end

  // A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (tmr_expired) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rf_ptr_w  = dst_q;
  assign rf_di     = rdata_q;

endmodule

// File: tb/tb_ls_unit.sv
// Scoreboard bench for ls_unit: a memory responder checks each request and
// acks after a programmed latency; completions are checked against a queue.
module tb_ls_unit;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic       st;
    logic [7:0] addr;
    logic [7:0] wd;
    int         lat;
    logic [7:0] rd;
  } mem_t;

  typedef struct {
    logic       we;
    logic [1:0] dst;
    logic [7:0] di;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic       op_store = 1'b0;
  logic [7:0] op_addr = '0;
  logic [7:0] op_wdata = '0;
  logic [1:0] op_dst = '0;
  logic       done;
  logic       err;
  logic       err_clr = 1'b0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       rf_we;
  logic [1:0] rf_ptr_w;
  logic [7:0] rf_di;

  mem_t mem_q[$];
  exp_t sb_q[$];
  int   req_cnt = 0;
  logic force_ack = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ls_unit #(
    .AW (8), .DW (8), .PW (2), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_store  (op_store),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .op_dst    (op_dst),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rf_we     (rf_we),
    .rf_ptr_w  (rf_ptr_w),
    .rf_di     (rf_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: acks in the lat-th REQ cycle; lat 0 never acks.
  always @(negedge clk) begin
    mem_t h;
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'h77;
    end else if (mem_req) begin
      if (mem_q.size() == 0) begin
        chk("req_unexp", 1, 0);
      end else begin
        h = mem_q[0];
        req_cnt++;
        chk("mem_we", mem_we, h.st);
        chk("mem_addr", mem_addr, h.addr);
        if (h.st) chk("mem_wdata", mem_wdata, h.wd);
        mem_rdata = 8'($urandom);
        if (h.lat != 0 && req_cnt == h.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = h.rd;
          void'(mem_q.pop_front());
          req_cnt = 0;
        end
      end
    end else if (req_cnt != 0) begin
      if (mem_q.size() != 0) begin
        if (mem_q[0].lat == 0) chk("to_len", req_cnt, TIMEOUT);
        void'(mem_q.pop_front());
      end
      req_cnt = 0;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("req_in_fin", mem_req, 0);
      if (sb_q.size() == 0) begin
        chk("done_unexp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
          chk("rf_ptr_w", rf_ptr_w, e.dst);
          chk("rf_di", rf_di, e.di);
        end
        chk("err_at_done", err, e.err);
      end
    end else if (rf_we) begin
      chk("rf_we_nodone", 1, 0);
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with op_valid still high.
  task automatic issue(input logic st, input logic [7:0] a, input logic [7:0] wd,
                       input logic [1:0] d, input int lat, input logic [7:0] rd,
                       input logic exp_err);
    int n = 0;
    mem_q.push_back('{st: st, addr: a, wd: wd, lat: lat, rd: rd});
    sb_q.push_back('{we: !st && lat != 0, dst: d, di: rd, err: exp_err});
    op_valid = 1'b1;
    op_store = st;
    op_addr  = a;
    op_wdata = wd;
    op_dst   = d;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || mem_q.size() != 0 || !op_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("idle_timeout", 0, 1);
      sb_q.delete();
      mem_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_di", rf_di, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load with immediate ack: exact cycle timing.
    issue(1'b0, 8'h10, 8'h00, 2'd2, 1, 8'hA5, 1'b0);
    op_valid = 1'b0;
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_ready_low", op_ready, 0);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_rf_we", rf_we, 1);
    @(negedge clk);
    chk("t1_ready", op_ready, 1);
    chk("t1_done_pulse", done, 0);

    // Store, 3-cycle ack.
    issue(1'b1, 8'hFF, 8'h3C, 2'd1, 3, 8'hEE, 1'b0);
    op_valid = 1'b0;
    wait_idle();

    // Load timeout, then clear.
    issue(1'b0, 8'h40, 8'h00, 2'd3, 0, 8'h00, 1'b1);
    op_valid = 1'b0;
    wait_idle();
    chk("to_err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);

    // Timeout while err_clr is held: set wins.
    err_clr = 1'b1;
    issue(1'b1, 8'h55, 8'h12, 2'd0, 0, 8'h00, 1'b1);
    op_valid = 1'b0;
    wait_idle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_after_clr", err, 0);

    // Back-to-back ops with op_valid held.
    issue(1'b0, 8'h20, 8'h00, 2'd1, 2, 8'h11, 1'b0);
    issue(1'b1, 8'h21, 8'h99, 2'd0, 1, 8'hEE, 1'b0);
    issue(1'b0, 8'h22, 8'h00, 2'd3, 4, 8'h6B, 1'b0);
    op_valid = 1'b0;
    wait_idle();

    // Spurious ack in IDLE.
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("spur_ready", op_ready, 1);
    chk("spur_req", mem_req, 0);
    chk("spur_done", done, 0);

    // Ack in the last allowed REQ cycle.
    issue(1'b0, 8'h80, 8'h00, 2'd0, TIMEOUT, 8'h5A, 1'b0);
    op_valid = 1'b0;
    wait_idle();
    chk("limit_err", err, 0);

    // Reset during REQ.
    issue(1'b0, 8'h90, 8'h00, 2'd2, 50, 8'hBB, 1'b0);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_ready", op_ready, 1);
    repeat (2) @(negedge clk);
    chk("rst_mid_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rel_ready", op_ready, 1);
    chk("rst_rel_rf_we", rf_we, 0);
    mem_q.delete();

    // Recovery after reset.
    issue(1'b0, 8'h33, 8'h00, 2'd3, 2, 8'hC3, 1'b0);
    op_valid = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
